// File: rtl/pe_ctx_seq.sv
// CGRA processing element: loadable context memory, looping context sequencer,
// four-entry register file, 1-bit predicate and NUM_EDGE registered output channels.
module pe_ctx_seq #(
    parameter int DW        = 32,
    parameter int NUM_EDGE  = 4,
    parameter int CTX_DEPTH = 16,
    localparam int AW       = $clog2(CTX_DEPTH)
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   ld_write,
    input  logic [AW-1:0]          ld_addr,
    input  logic [31:0]            ld_data,
    input  logic                   start,
    input  logic [AW:0]            ctx_len,
    input  logic [15:0]            iter_count,
    input  logic [NUM_EDGE*DW-1:0] edge_in,
    output logic [NUM_EDGE*DW-1:0] edge_out,
    output logic [NUM_EDGE-1:0]    edge_vld,
    output logic                   pred_out,
    output logic                   busy,
    output logic                   done,
    output logic [AW-1:0]          pc_out
);
    localparam int SHW = $clog2(DW);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_t;

    state_t                 state_q, state_d;
    logic [AW-1:0]          pc_q, pc_d;
    logic [AW:0]            len_q, len_d;
    logic [15:0]            iter_q, iter_d;
    logic [DW-1:0]          r_q [4];
    logic [DW-1:0]          r_d [4];
    logic                   p_q, p_d;
    logic [NUM_EDGE*DW-1:0] eout_q, eout_d;
    logic [NUM_EDGE-1:0]    vld_q, vld_d;

    logic [31:0]            ctx_mem [CTX_DEPTH];
    logic [31:0]            instr;
    logic [DW-1:0]          edge_ch [NUM_EDGE];

    logic [3:0]             op, src_a, src_b;
    logic [1:0]             dst;
    logic                   wb_en, pred_en, exec;
    logic [DW-1:0]          imm, op_a, op_b, alu_res;
    logic                   alu_wr;
    logic [NUM_EDGE-1:0]    out_mask;

    generate
        for (genvar gi = 0; gi < NUM_EDGE; gi++) begin : g_edge
            assign edge_ch[gi] = edge_in[gi*DW +: DW];
        end
        if (NUM_EDGE < 8) begin : g_mask_pad
            logic unused_mask_bits;
            assign unused_mask_bits = ^instr[30:23+NUM_EDGE];
        end
    endgenerate

    // Writes land only while idle; the asynchronous read lets a word written
    // together with start be executed in the very first RUN cycle.
    always_ff @(posedge CLK) begin
        if (ld_write && state_q == ST_IDLE) begin
            ctx_mem[ld_addr] <= ld_data;
        end
    end

    assign instr    = ctx_mem[pc_q];
    assign op       = instr[3:0];
    assign src_a    = instr[7:4];
    assign src_b    = instr[11:8];
    assign dst      = instr[13:12];
    assign wb_en    = instr[14];
    assign imm      = DW'(instr[22:15]);
    assign out_mask = instr[23 +: NUM_EDGE];
    assign pred_en  = instr[31];

    always_comb begin
        op_a = '0;
        op_b = '0;
        for (int i = 0; i < NUM_EDGE; i++) begin
            if (src_a == 4'(i)) op_a = edge_ch[i];
            if (src_b == 4'(i)) op_b = edge_ch[i];
        end
        for (int i = 0; i < 4; i++) begin
            if (src_a == 4'(8 + i)) op_a = r_q[i];
            if (src_b == 4'(8 + i)) op_b = r_q[i];
        end
        if (src_a == 4'd12) op_a = imm;
        if (src_b == 4'd12) op_b = imm;
    end

    always_comb begin
        alu_res = '0;
        alu_wr  = 1'b0;
        case (op)
            4'd1: begin alu_res = op_a + op_b;             alu_wr = 1'b1; end
            4'd2: begin alu_res = op_a - op_b;             alu_wr = 1'b1; end
            4'd3: begin alu_res = op_a & op_b;             alu_wr = 1'b1; end
            4'd4: begin alu_res = op_a | op_b;             alu_wr = 1'b1; end
            4'd5: begin alu_res = op_a ^ op_b;             alu_wr = 1'b1; end
            4'd6: begin alu_res = op_a << op_b[SHW-1:0];   alu_wr = 1'b1; end
            4'd7: begin alu_res = op_a >> op_b[SHW-1:0];   alu_wr = 1'b1; end
            4'd8: begin alu_res = op_a;                    alu_wr = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        len_d   = len_q;
        iter_d  = iter_q;
        p_d     = p_q;
        eout_d  = eout_q;
        vld_d   = '0;
        exec    = 1'b0;
        for (int i = 0; i < 4; i++) r_d[i] = r_q[i];

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d  = (ctx_len > (AW+1)'(CTX_DEPTH)) ? (AW+1)'(CTX_DEPTH) : ctx_len;
                    iter_d = iter_count;
                    pc_d   = '0;
                    state_d = (ctx_len == '0 || iter_count == 16'd0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                exec = !(pred_en && !p_q);
                if (exec) begin
                    if (op == 4'd9)  p_d = (op_a < op_b);
                    if (op == 4'd10) p_d = (op_a == op_b);
                    if (alu_wr) begin
                        if (wb_en) r_d[dst] = alu_res;
                        for (int i = 0; i < NUM_EDGE; i++) begin
                            if (out_mask[i]) begin
                                eout_d[i*DW +: DW] = alu_res;
                                vld_d[i]           = 1'b1;
                            end
                        end
                    end
                end
                if ({1'b0, pc_q} == len_q - (AW+1)'(1)) begin
                    pc_d   = '0;
                    iter_d = iter_q - 16'd1;
                    if (iter_q == 16'd1) state_d = ST_DONE;
                end else begin
                    pc_d = pc_q + AW'(1);
                end
                // HALT overrides loop bookkeeping; a squashed HALT is a plain NOP.
                if (exec && op == 4'd15) begin
                    state_d = ST_DONE;
                    pc_d    = '0;
                end
            end
            ST_DONE: begin
                pc_d    = '0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            len_q   <= '0;
            iter_q  <= '0;
            p_q     <= 1'b0;
            eout_q  <= '0;
            vld_q   <= '0;
            for (int i = 0; i < 4; i++) r_q[i] <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            len_q   <= len_d;
            iter_q  <= iter_d;
            p_q     <= p_d;
            eout_q  <= eout_d;
            vld_q   <= vld_d;
            for (int i = 0; i < 4; i++) r_q[i] <= r_d[i];
        end
    end

    assign edge_out = eout_q;
    assign edge_vld = vld_q;
    assign pred_out = p_q;
    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign pc_out   = pc_q;

endmodule
